// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that shares one FIFO write port among NREQ burst requesters.
// Latency: a request seen in IDLE at cycle N gets its first possible grant at N+1; one IDLE bubble between bursts.
// Backpressure: wfull stalls the owner in place (winc/gnt low, beat held); everyone else waits for the burst to end.
//
// Ports: clk/rst (async active-high) | req, req_data[i*DW+:DW], req_last per requester |
//        gnt one-hot beat accept | wfull in, winc/wdata out to the FIFO | owner, busy status |
//        burst_cnt: NREQ x 8-bit completed-burst counters.
// Optional: define FIFO_WR_ARB_STATS_EN for saturating burst counters; otherwise burst_cnt is all-zero.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   gnt,
  input  logic              wfull,
  output logic              winc,
  output logic [DW-1:0]     wdata,
  output logic [2:0]        owner,
  output logic              busy,
  output logic [8*NREQ-1:0] burst_cnt
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  last_ptr_q, last_ptr_d;
  logic [4:0]  beat_q, beat_d;

  logic          own_req, own_last;
  logic [DW-1:0] own_data;
  logic          pick_vld;
  logic [2:0]    pick_idx;
  logic          final_beat;

  // Owner-side view of the request bus. Decoded with a compare loop so the
  // 3-bit owner index never has to be narrowed to fit a smaller NREQ.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin search starting just after the previous owner; the outer
  // loop is the search distance so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_vld && req[i] && (i == (int'(last_ptr_q) + k) % NREQ)) begin
          pick_vld = 1'b1;
          pick_idx = 3'(i);
        end
      end
    end
  end

  assign winc       = (state_q == BURST) & own_req & ~wfull;
  assign final_beat = winc & (own_last | (beat_q == 5'(MAX_BURST - 1)));
  assign wdata      = own_data;
  assign owner      = owner_q;
  assign busy       = (state_q == BURST);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winc && owner_q == 3'(i)) gnt[i] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    beat_d     = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && !wfull) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (final_beat) begin
          state_d    = IDLE;
          last_ptr_d = owner_q;
          beat_d     = '0;
        end else if (winc) begin
          beat_d = beat_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_ptr_q <= 3'(NREQ - 1);
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
      beat_q     <= beat_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [8*NREQ-1:0] cnt_q, cnt_d;

  // Counters saturate at 255 rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (final_beat && owner_q == 3'(i) && cnt_q[i*8 +: 8] != 8'hFF) begin
        cnt_d[i*8 +: 8] = cnt_q[i*8 +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign burst_cnt = cnt_q;
`else
  assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int MAXB = 8;
`ifdef FIFO_WR_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, req_last, gnt;
  logic [NREQ*DW-1:0] req_data;
  logic               wfull, winc, busy;
  logic [DW-1:0]      wdata;
  logic [2:0]         owner;
  logic [8*NREQ-1:0]  burst_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .wfull(wfull), .winc(winc), .wdata(wdata), .owner(owner),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  // Reference model: who holds the port, how many beats it has written,
  // where the round-robin search resumes, and completed bursts per requester.
  bit m_busy;
  int m_owner, m_last, m_beats;
  int m_cnt[NREQ];
  int m_pick;

  function automatic bit m_bit(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic bit m_write();
    return m_busy && m_bit(req, m_owner) && !wfull;
  endfunction

  function automatic logic [8*NREQ-1:0] exp_cnt();
    logic [8*NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i*8 +: 8] = STATS ? 8'(m_cnt[i]) : 8'd0;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else if (!m_busy) begin
      if (req != 0 && !wfull) begin
        m_pick = -1;
        for (int k = 1; k <= NREQ; k++)
          if (m_pick < 0 && m_bit(req, (m_last + k) % NREQ)) m_pick = (m_last + k) % NREQ;
        m_busy = 1; m_owner = m_pick; m_beats = 0;
      end
    end else if (m_write()) begin
      m_beats++;
      if (m_bit(req_last, m_owner) || m_beats == MAXB) begin
        m_busy = 0; m_last = m_owner;
        if (m_cnt[m_owner] < 255) m_cnt[m_owner]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    req[i] = v; req_last[i] = l; req_data[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    tick();
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    #2;
    req = '1; req_last = '1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b exp 0", winc); end
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    checks++; if (burst_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h exp 0", burst_cnt); end
    @(negedge clk); rst = 1'b0; req = '0; req_last = '0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    set_lane(0, 1'b1, 4'hA, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || winc !== 1'b0) begin errors++; $display("FAIL single_bubble got busy=%b winc=%b exp 0 0", busy, winc); end
    tick();
    for (int b = 0; b < 3; b++) begin
      set_lane(0, 1'b1, 4'(4'hA + b), b == 2);
      @(negedge clk);
      checks++; if (winc !== 1'b1 || gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt b=%0d got winc=%b gnt=%b exp 1 0001", b, winc, gnt); end
      checks++; if (wdata !== 4'(4'hA + b)) begin errors++; $display("FAIL single_wdata b=%0d got %h exp %h", b, wdata, 4'(4'hA + b)); end
      tick();
    end
    set_lane(0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got %b exp 0", busy); end
    checks++; if (burst_cnt[7:0] !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL single_cnt got %0d exp %0d", burst_cnt[7:0], STATS ? 1 : 0); end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, 4'(i + 5), 1'b1);
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || winc !== 1'b0) begin errors++; $display("FAIL fair_bubble g=%0d got busy=%b winc=%b exp 0 0", g, busy, winc); end
      tick();
      @(negedge clk);
      checks++; if (gnt !== 4'(1 << (g % NREQ)) || wdata !== 4'((g % NREQ) + 5)) begin
        errors++; $display("FAIL fair_order g=%0d got gnt=%b wdata=%h exp gnt=%b wdata=%h", g, gnt, wdata, 4'(1 << (g % NREQ)), 4'((g % NREQ) + 5));
      end
      tick();
    end
  endtask

  task automatic test_max_burst();
    apply_reset();
    set_lane(2, 1'b1, 4'h0, 1'b0);
    tick();
    for (int b = 0; b < MAXB; b++) begin
      set_lane(2, 1'b1, 4'(b), 1'b0);
      @(negedge clk);
      checks++; if (winc !== 1'b1 || gnt !== 4'b0100 || wdata !== 4'(b)) begin
        errors++; $display("FAIL cap_beat b=%0d got winc=%b gnt=%b wdata=%h exp 1 0100 %h", b, winc, gnt, wdata, 4'(b));
      end
      tick();
    end
    set_lane(2, 1'b1, 4'h8, 1'b0);
    set_lane(0, 1'b1, 4'hE, 1'b1);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cap_idle got busy=%b exp 0", busy); end
    tick();
    @(negedge clk);
    checks++; if (owner !== 3'd0 || gnt !== 4'b0001) begin errors++; $display("FAIL cap_rr got owner=%0d gnt=%b exp 0 0001", owner, gnt); end
    tick();
    set_lane(0, 1'b0, 4'h0, 1'b0);
    tick();
    @(negedge clk);
    checks++; if (owner !== 3'd2 || gnt !== 4'b0100 || wdata !== 4'h8) begin
      errors++; $display("FAIL cap_regrant got owner=%0d gnt=%b wdata=%h exp 2 0100 8", owner, gnt, wdata);
    end
  endtask

  task automatic test_backpressure();
    int b;
    int nw;
    apply_reset();
    b = 0; nw = 0;
    set_lane(1, 1'b1, 4'h1, 1'b0);
    tick();
    for (int c = 0; c < 9; c++) begin
      wfull = (c >= 2 && c < 6);
      set_lane(1, 1'b1, 4'(b + 1), b == 4);
      @(negedge clk);
      if (wfull) begin
        checks++; if (winc !== 1'b0 || gnt !== '0 || owner !== 3'd1 || busy !== 1'b1) begin
          errors++; $display("FAIL bp_stall c=%0d got winc=%b gnt=%b owner=%0d busy=%b exp 0 0000 1 1", c, winc, gnt, owner, busy);
        end
      end else begin
        checks++; if (winc !== 1'b1 || wdata !== 4'(b + 1)) begin
          errors++; $display("FAIL bp_beat c=%0d got winc=%b wdata=%h exp 1 %h", c, winc, wdata, 4'(b + 1));
        end
      end
      if (winc === 1'b1) nw++;
      tick();
      if (!wfull) b++;
    end
    wfull = 1'b0;
    set_lane(1, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checks++; if (nw != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", nw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_lane(1, 1'b1, 4'h3, 1'b0);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (winc !== 1'b0 || gnt !== '0 || busy !== 1'b0 || owner !== 3'd0) begin
      errors++; $display("FAIL rstmid_async got winc=%b gnt=%b busy=%b owner=%0d exp 0 0000 0 0", winc, gnt, busy, owner);
    end
    set_lane(0, 1'b1, 4'h7, 1'b1);
    set_lane(1, 1'b1, 4'h9, 1'b1);
    @(negedge clk); rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || wdata !== 4'h7) begin errors++; $display("FAIL rstmid_first got gnt=%b wdata=%h exp 0001 7", gnt, wdata); end
  endtask

  task automatic test_random();
    int rem[NREQ];
    logic [DW-1:0] ld[NREQ];
    int g;
    logic [NREQ-1:0] eg;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; ld[i] = 4'($urandom); end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 12);
        set_lane(i, rem[i] != 0, ld[i], rem[i] == 1);
      end
      wfull = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      eg = m_write() ? 4'(1 << m_owner) : 4'b0000;
      checks++; if (winc !== m_write() || gnt !== eg) begin
        errors++; $display("FAIL rand_gnt cyc=%0d got winc=%b gnt=%b exp %b %b", cyc, winc, gnt, m_write(), eg);
      end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got %b exp %b", cyc, busy, m_busy); end
      if (m_busy) begin
        checks++; if (owner !== 3'(m_owner) || wdata !== DW'(req_data >> (m_owner * DW))) begin
          errors++; $display("FAIL rand_owner cyc=%0d got owner=%0d wdata=%h exp %0d %h", cyc, owner, wdata, m_owner, DW'(req_data >> (m_owner * DW)));
        end
      end
      checks++; if (burst_cnt !== exp_cnt()) begin errors++; $display("FAIL rand_cnt cyc=%0d got %h exp %h", cyc, burst_cnt, exp_cnt()); end
      g = m_write() ? m_owner : -1;
      tick();
      if (g >= 0) begin rem[g]--; ld[g] = 4'($urandom); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_lane(1, 1'b1, 4'h5, 1'b1);
    for (int n = 1; n <= 300; n++) begin
      tick(); tick();
      if (n == 200) begin
        checks++; if (burst_cnt[15:8] !== (STATS ? 8'd200 : 8'd0)) begin
          errors++; $display("FAIL sat_mid got %0d exp %0d", burst_cnt[15:8], STATS ? 200 : 0);
        end
      end
    end
    checks++; if (burst_cnt[15:8] !== (STATS ? 8'd255 : 8'd0)) begin
      errors++; $display("FAIL sat_end got %0d exp %0d", burst_cnt[15:8], STATS ? 255 : 0);
    end
    checks++; if (burst_cnt[7:0] !== 8'd0 || burst_cnt[31:16] !== 16'd0) begin
      errors++; $display("FAIL sat_others got %h exp 0", burst_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_max_burst();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter for the 4-bit async FIFO write side; lives entirely in the wclk domain.
- Shares the single FIFO write port (winc/wdata, back-pressured by wfull) among NREQ requesters.
- Each grant is a burst that ends on the requester's last flag or at MAX_BURST beats, whichever comes first.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width per requester; matches FIFO wdata.
- MAX_BURST, 8, maximum beats per grant (1..16).

Ports:
- clk  input  1  write-domain clock (FIFO wclk).
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; data valid when high.
- req_data  input  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- req_last  input  NREQ  marks the final beat of the requester's burst.
- gnt  output  NREQ  one-hot beat accept; beat i is transferred in a cycle where gnt[i]=1.
- wfull  input  1  FIFO full flag, same clock.
- winc  output  1  FIFO write enable.
- wdata  output  DW  FIFO write data.
- owner  output  3  index of the current burst owner; valid while busy=1.
- busy  output  1  high in BURST state.
- burst_cnt  output  8*NREQ  per-requester completed-burst counters (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-high. Clock is clk.
- Reset values: state=IDLE, owner=0, last_ptr=NREQ-1 (requester 0 wins first), beat=0, busy=0, winc=0, gnt=0, burst_cnt=0.
- FSM states: IDLE and BURST.
- IDLE:
  - When |req is high and wfull=0, pick the first requester with req set, searching last_ptr+1, last_ptr+2, ... modulo NREQ.
  - Register it as owner, clear beat, move to BURST next cycle.
  - While wfull=1, stay in IDLE and make no selection.
- BURST, combinational from registered state:
  - winc = req[owner] & ~wfull.
  - gnt = winc ? (1<<owner) : 0.
  - wdata = req_data[owner], always driven, including when winc=0.
- Beat counter: beat increments on every cycle with winc=1.
- Burst end: a beat with winc=1 and (req_last[owner]=1 or beat==MAX_BURST-1) is the final beat. Next cycle: state=IDLE, last_ptr=owner, burst_cnt[owner] increments.
- Owner keeps the port while req[owner]=0 or wfull=1. No timeout, no preemption. Other requests wait.
- Latency: a request seen in IDLE at cycle N gives its first possible gnt at cycle N+1. There is exactly one IDLE bubble cycle between back-to-back bursts.
- gnt is at most one-hot. Non-owners always see gnt=0.
- wfull rising mid-burst: winc and gnt drop in the same cycle, beat is held, and the burst resumes when wfull falls.
- req_last with winc=0 is ignored.
- A single-beat burst (req_last on the first beat) is legal.
- Reset asserted mid-burst: all outputs go to their reset values immediately. The partial burst is not resumed, and beats already written stay in the FIFO.
- Requester changing req_data while gnt=0 is legal.
- Requester must hold req and req_data until it sees gnt.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: burst_cnt holds NREQ 8-bit counters. Each increments by 1 per completed burst and saturates at 255. Cleared only by rst.
- Undefined: burst_cnt is tied to all-zero, with no counter flops.
- Arbitration and timing are identical either way.

Test Plan:
- Single requester: req=0001, 3 beats 0xA,0xB,0xC, req_last on 0xC. Expect one IDLE cycle, then winc=1 for 3 consecutive cycles, wdata=A,B,C, gnt=0001, then busy=0. Stats: burst_cnt[0]=1.
- Fairness: req=1111, all bursts single-beat, all always requesting. Expect grants in order 0,1,2,3,0,... with one IDLE cycle between each.
- MAX_BURST cap: requester 2 streams 12 beats and never asserts req_last. Expect 8 writes, then IDLE, then a new grant; requester 2 wins again only if no other requester is active.
- Back-pressure: wfull asserted after beat 2 of 5 for 4 cycles. Expect winc=0 and gnt=0 for those 4 cycles, owner unchanged, then beats 3-5 written; total winc count = 5.
- Reset mid-burst: rst pulsed asynchronously between clock edges during beat 3. Expect winc, gnt and busy low immediately; after release with req=0011, requester 0 is granted first.
- Stats saturation, with FIFO_WR_ARB_STATS_EN: 300 single-beat bursts on requester 1. Expect burst_cnt[1]=255. Without the macro, burst_cnt=0 throughout.
